mask_stream_unit: RTL and testbench
===================================

// Module: mask_stream_unit
// PURPOSE
//  Multi-cycle, parametrised RVV mask unit. Processes a VLEN-bit mask register as CHUNK_W-bit chunks, one per cycle.
//  Carries cross-chunk state (running popcount, first-found flag/index) for vpopc, vfirst, vmsbf/vmsif/vmsof and viota bases.
//  Sits between the vector register file read port and the lane writeback; scalar results go to the xreg writeback.
// PARAMETERS
//  VLEN     128  mask register length in bits (elements); multiple of CHUNK_W
//  CHUNK_W  32   bits processed per cycle; power of two
//  XLEN     32   scalar result width
// PORTS
//  CLK          in   1                 clock
//  RST          in   1                 asynchronous reset, active-high
//  start        in   1                 begin op; sampled only in IDLE
//  mask_type    in   mask_op_t         AND/OR/XOR/POPC/FIRST/SBF/SIF/SOF/IOTA, latched at start
//  in_inv       in   1                 invert vs1 chunk (logical ops), latched at start
//  out_inv      in   1                 invert logical result, latched at start
//  vl           in   $clog2(VLEN)+1    active element count, latched at start
//  in_valid     in   1                 vs2/vs1/vm chunk present
//  in_ready     out  1                 chunk accepted when in_valid & in_ready
//  vs2_chunk    in   CHUNK_W           source mask chunk
//  vs1_chunk    in   CHUNK_W           second operand (logical ops)
//  vm_chunk     in   CHUNK_W           v0 enable bits; all-ones when unmasked
//  out_valid    out  1                 result chunk valid
//  out_ready    in   1                 downstream accepts result chunk
//  out_chunk    out  CHUNK_W           result chunk
//  out_wen      out  CHUNK_W           per-bit write enable (body & active)
//  out_idx      out  $clog2(VLEN/CHUNK_W) chunk index of out_chunk
//  iota_base    out  XLEN              active set-bit count of all earlier chunks (IOTA)
//  scalar_res   out  XLEN              POPC count / FIRST index (-1 if none)
//  done         out  1                 one-cycle pulse: op complete, scalar_res valid
//  busy         out  1                 state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except scalar_res=0; accumulators, found flag, chunk counter cleared.
//  FSM IDLE -> RUN on start (vl>0); IDLE -> DONE on start with vl==0; RUN -> DONE after last chunk accepted; DONE -> IDLE next cycle.
//  Last chunk index = ceil(vl/CHUNK_W)-1; chunks fed strictly in order from index 0; no chunk beyond it is requested.
//  in_ready = RUN & (!out_valid | out_ready); single output register, latency 1 cycle input->out_valid.
//  out_valid holds with stable data until out_ready; done pulses in DONE, after last chunk drained from output reg.
//  POPC/FIRST produce no out_valid; chunks consumed at 1/cycle.
//  Active bit b of chunk k: (k*CHUNK_W+b < vl) & vm_chunk[b]; inactive bits are excluded from POPC/FIRST/SBF scans.
//  AND/OR/XOR: out = f(vs2, in_inv?~vs1:vs1), inverted if out_inv; out_wen = body bits (element < vl), vm ignored.
//  SBF/SIF/SOF: out_wen = active bits; before first set active bit: SBF=1,SIF=1,SOF=0; at it: SBF=0,SIF=1,SOF=1;
//   after it (same or later chunks, found flag set): all 0. No set bit anywhere: SBF/SIF all 1, SOF all 0.
//  FIRST: scalar_res = global index k*CHUNK_W+b of first active set bit; all-ones if none. Later chunks don't overwrite.
//  POPC: scalar_res = sum of active set bits, width XLEN, no overflow possible (VLEN < 2^XLEN).
//  IOTA: out_chunk = vs2_chunk (passthrough for lane prefix), iota_base = running count before this chunk; out_wen = active.
//  start while busy: ignored. in_valid outside RUN: ignored. RST mid-op: abort to IDLE, no done.
//  Found flag, count and index update on the accepting edge only; simultaneous output drain and new accept allowed.
// STRUCTURE
//  rv32v_types_pkg: mask_op_t enum (shared with decode), msu_state_t {IDLE,RUN,DONE}.
//  Sub-module mask_chunk_scan: combinational CHUNK_W scan -> lowest active set index, found, popcount, prefix mask.
//  Top holds FSM, chunk counter, accumulators, output register.
// TESTING
//  VLEN=128,CHUNK_W=32, POPC vl=128 vs2=all-ones vm=all-ones -> 4 accepts, done, scalar_res=128.
//  FIRST vl=100, only bit 70 set -> scalar_res=70; same with vm bit 70=0 -> scalar_res=0xFFFFFFFF.
//  SIF vl=64, vs2 bit 40 set -> chunk0=FFFFFFFF, chunk1=000001FF; SOF chunk1=00000100; SBF chunk1=000000FF.
//  vl=0 start -> no in_ready, done one cycle after start, POPC=0, FIRST=-1.
//  XOR in_inv=1 out_inv=0, vl=40, out_ready low 3 cycles -> out_chunk held, in_ready low, out_wen chunk1=000000FF.
//  RST asserted mid-RUN after chunk1 -> busy=0, out_valid=0, next op counts from zero.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared RVV mask-unit types: the mask operation encoding used by decode and
// the mask streaming unit, plus the streaming unit's FSM state encoding.
package rv32v_types_pkg;

    typedef enum logic [3:0] {
        MASK_AND   = 4'd0,
        MASK_OR    = 4'd1,
        MASK_XOR   = 4'd2,
        MASK_POPC  = 4'd3,
        MASK_FIRST = 4'd4,
        MASK_SBF   = 4'd5,
        MASK_SIF   = 4'd6,
        MASK_SOF   = 4'd7,
        MASK_IOTA  = 4'd8
    } mask_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } msu_state_t;

    // Scalar-result ops (vpopc/vfirst) never write a result chunk back.
    function automatic logic op_has_output(input mask_op_t op);
        return !(op == MASK_POPC || op == MASK_FIRST);
    endfunction

endpackage

// File: rtl/mask_chunk_scan.sv
// Combinational scan of one mask chunk (already qualified by the active
// bits): lowest set position, whether any bit is set, the set-bit count and
// the mask of positions strictly below the first set bit (all ones if none).
module mask_chunk_scan #(
    parameter int CHUNK_W = 32
) (
    input  logic [CHUNK_W-1:0]         bits_i,
    output logic                       found_o,
    output logic [$clog2(CHUNK_W)-1:0] first_o,
    output logic [$clog2(CHUNK_W):0]   popcnt_o,
    output logic [CHUNK_W-1:0]         before_o
);

    localparam int LOG_CW = $clog2(CHUNK_W);

    // Priority scan from bit 0 upward, counting set bits along the way.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        found_o  = 1'b0;
        first_o  = '0;
        popcnt_o = '0;
        before_o = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            // NOTE: blocking assignments here are intentional: each iteration
            // must see the found/count values updated by the previous one.
            popcnt_o = popcnt_o + (LOG_CW + 1)'(bits_i[b]);
            if (!found_o) begin
                if (bits_i[b]) begin
                    found_o = 1'b1;
                    first_o = LOG_CW'(b);
                end else begin
                    before_o[b] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mask_stream_unit.sv
// RVV mask unit that streams a VLEN-bit mask register as CHUNK_W-bit chunks,
// one per cycle, carrying running popcount and first-found state across
// chunks for vpopc, vfirst, vmsbf/vmsif/vmsof, viota bases and mask logicals.
module mask_stream_unit
    import rv32v_types_pkg::*;
#(
    parameter int VLEN    = 128,
    parameter int CHUNK_W = 32,
    parameter int XLEN    = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  mask_op_t                          mask_type_i,
    input  logic                              in_inv_i,
    input  logic                              out_inv_i,
    input  logic [$clog2(VLEN):0]             vl_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [CHUNK_W-1:0]                vs2_chunk_i,
    input  logic [CHUNK_W-1:0]                vs1_chunk_i,
    input  logic [CHUNK_W-1:0]                vm_chunk_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [CHUNK_W-1:0]                out_chunk_o,
    output logic [CHUNK_W-1:0]                out_wen_o,
    output logic [$clog2(VLEN/CHUNK_W)-1:0]   out_idx_o,
    output logic [XLEN-1:0]                   iota_base_o,
    output logic [XLEN-1:0]                   scalar_res_o,
    output logic                              done_o,
    output logic                              busy_o
);

    localparam int VL_W   = $clog2(VLEN) + 1;
    localparam int IDX_W  = $clog2(VLEN / CHUNK_W);
    localparam int LOG_CW = $clog2(CHUNK_W);

    msu_state_t          state_q, state_d;
    mask_op_t            op_q;
    logic                in_inv_q, out_inv_q;
    logic [VL_W-1:0]     vl_q;
    logic [IDX_W-1:0]    idx_q;
    logic                all_acc_q;
    logic                found_q;
    logic [XLEN-1:0]     count_q, first_q;

    logic                out_valid_q;
    logic [CHUNK_W-1:0]  out_chunk_q, out_wen_q;
    logic [IDX_W-1:0]    out_idx_q;
    logic [XLEN-1:0]     iota_base_q;

    logic                accept, is_last, has_out;
    logic [CHUNK_W-1:0]  body, active, vs1_eff, logic_res, onehot, chunk_res, wen_res;
    logic                scan_found;
    logic [LOG_CW-1:0]   scan_first;
    logic [LOG_CW:0]     scan_cnt;
    logic [CHUNK_W-1:0]  scan_before;

    assign has_out    = op_has_output(op_q);
    assign in_ready_o = (state_q == RUN) && !all_acc_q && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    // The current chunk is the last one when the next chunk would start at or beyond vl.
    assign is_last    = (({1'b0, idx_q, {LOG_CW{1'b0}}} + VL_W'(CHUNK_W)) >= vl_q);

    // Body (element < vl) and active (body & v0) bits of the current chunk.
    always_comb begin
        body   = '0;
        active = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            body[b]   = ({1'b0, idx_q, LOG_CW'(b)} < vl_q);
            active[b] = body[b] & vm_chunk_i[b];
        end
    end

    mask_chunk_scan #(.CHUNK_W(CHUNK_W)) u_scan (
        .bits_i   (vs2_chunk_i & active),
        .found_o  (scan_found),
        .first_o  (scan_first),
        .popcnt_o (scan_cnt),
        .before_o (scan_before)
    );

    // Result chunk and write enables for the op latched at start.
    always_comb begin
        vs1_eff   = in_inv_q ? ~vs1_chunk_i : vs1_chunk_i;
        onehot    = scan_found ? (CHUNK_W'(1) << scan_first) : '0;
        logic_res = '0;
        chunk_res = '0;
        wen_res   = active;
        case (op_q)
            MASK_AND: logic_res = vs2_chunk_i & vs1_eff;
            MASK_OR:  logic_res = vs2_chunk_i | vs1_eff;
            MASK_XOR: logic_res = vs2_chunk_i ^ vs1_eff;
            default:  logic_res = '0;
        endcase
        case (op_q)
            MASK_AND, MASK_OR, MASK_XOR: begin
                chunk_res = out_inv_q ? ~logic_res : logic_res;
                wen_res   = body;
            end
            // Once the first set bit was seen in an earlier chunk, everything is 0.
            MASK_SBF:  chunk_res = found_q ? '0 : scan_before;
            MASK_SIF:  chunk_res = found_q ? '0 : (scan_before | onehot);
            MASK_SOF:  chunk_res = found_q ? '0 : onehot;
            MASK_IOTA: chunk_res = vs2_chunk_i;
            default:   chunk_res = '0;
        endcase
    end

    // Next-state logic; output ops leave RUN only once the last chunk has drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = (vl_i == '0) ? DONE : RUN;
            RUN: begin
                if (accept && is_last && !has_out) begin
                    state_d = DONE;
                end else if (all_acc_q && (!out_valid_q || out_ready_i)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Op latch at start, chunk counter and cross-chunk accumulators.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= MASK_AND;
            in_inv_q  <= 1'b0;
            out_inv_q <= 1'b0;
            vl_q      <= '0;
            idx_q     <= '0;
            all_acc_q <= 1'b0;
            found_q   <= 1'b0;
            count_q   <= '0;
            first_q   <= '0;
        end else if (state_q == IDLE && start_i) begin
            op_q      <= mask_type_i;
            in_inv_q  <= in_inv_i;
            out_inv_q <= out_inv_i;
            vl_q      <= vl_i;
            idx_q     <= '0;
            all_acc_q <= 1'b0;
            found_q   <= 1'b0;
            count_q   <= '0;
            first_q   <= '0;
        end else if (accept) begin
            idx_q   <= idx_q + IDX_W'(1);
            count_q <= count_q + XLEN'(scan_cnt);
            if (is_last) all_acc_q <= 1'b1;
            if (!found_q && scan_found) begin
                found_q <= 1'b1;
                first_q <= XLEN'({idx_q, scan_first});
            end
        end
    end

    // Single output register: loads on accept, holds until out_ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_chunk_q <= '0;
            out_wen_q   <= '0;
            out_idx_q   <= '0;
            iota_base_q <= '0;
        end else if (accept && has_out) begin
            out_valid_q <= 1'b1;
            out_chunk_q <= chunk_res;
            out_wen_q   <= wen_res;
            out_idx_q   <= idx_q;
            iota_base_q <= count_q;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Scalar result reflects the accumulators of the latched op.
    always_comb begin
        case (op_q)
            MASK_POPC:  scalar_res_o = count_q;
            MASK_FIRST: scalar_res_o = found_q ? first_q : '1;
            default:    scalar_res_o = '0;
        endcase
    end

    assign out_valid_o = out_valid_q;
    assign out_chunk_o = out_chunk_q;
    assign out_wen_o   = out_wen_q;
    assign out_idx_o   = out_idx_q;
    assign iota_base_o = iota_base_q;
    assign done_o      = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mask_stream_unit.sv
// Self-checking bench for mask_stream_unit: directed scenarios plus randomized
// ops compared against a whole-register element-level reference model.
module tb_mask_stream_unit;
    import rv32v_types_pkg::*;

    localparam int VLEN = 128;
    localparam int CW   = 32;
    localparam int XLEN = 32;

    logic            clk, rst, start, in_inv, out_inv, in_valid, in_ready;
    mask_op_t        mask_type;
    logic [7:0]      vl_in;
    logic [CW-1:0]   vs2_chunk, vs1_chunk, vm_chunk, out_chunk, out_wen;
    logic            out_valid, out_ready, done, busy;
    logic [1:0]      out_idx;
    logic [XLEN-1:0] iota_base, scalar_res;

    logic [VLEN-1:0] vs2_full, vs1_full, vm_full;
    int              pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    bit              rand_ready = 1'b0;

    typedef struct {
        logic [CW-1:0]   chunk;
        logic [CW-1:0]   wen;
        logic [1:0]      idx;
        logic [XLEN-1:0] base;
    } out_rec_t;
    out_rec_t outq[$];
    int       acc_cnt;

    mask_stream_unit #(.VLEN(VLEN), .CHUNK_W(CW), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mask_type_i(mask_type),
        .in_inv_i(in_inv), .out_inv_i(out_inv), .vl_i(vl_in),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .vs2_chunk_i(vs2_chunk), .vs1_chunk_i(vs1_chunk), .vm_chunk_i(vm_chunk),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_chunk_o(out_chunk), .out_wen_o(out_wen), .out_idx_o(out_idx),
        .iota_base_o(iota_base), .scalar_res_o(scalar_res),
        .done_o(done), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes observed at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_rec_t r;
            r.chunk = out_chunk;
            r.wen   = out_wen;
            r.idx   = out_idx;
            r.base  = iota_base;
            outq.push_back(r);
        end
        if (!rst && in_valid && in_ready) acc_cnt++;
    end

    // Random downstream back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one op over vs2_full/vs1_full/vm_full and compare against the model.
    task automatic run_op(input mask_op_t op, input int vl, input logic ii, input logic oi, input string tag);
        int nch = (vl + CW - 1) / CW;
        int guard;
        int first_el = VLEN;
        int cnt = 0;
        logic [XLEN-1:0] exp_scalar;
        outq.delete();
        acc_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; mask_type = op; vl_in = 8'(vl); in_inv = ii; out_inv = oi;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < nch; k++) begin
            in_valid  = 1'b1;
            vs2_chunk = vs2_full[k*CW +: CW];
            vs1_chunk = vs1_full[k*CW +: CW];
            vm_chunk  = vm_full[k*CW +: CW];
            guard = 0;
            do begin @(negedge clk); guard++; end while (!in_ready && guard < 200);
            if (!in_ready) check($sformatf("%s_accept%0d", tag, k), in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        vs2_chunk = $urandom;
        guard = 0;
        while (!done && guard < 300) begin @(negedge clk); guard++; end
        check({tag, "_done"}, done, 1);

        // Reference model over whole element vectors.
        for (int i = 0; i < vl; i++) begin
            if (vm_full[i] && vs2_full[i]) begin
                if (first_el == VLEN) first_el = i;
                cnt++;
            end
        end
        if (op == MASK_POPC) begin
            check({tag, "_popc"}, scalar_res, cnt);
        end else if (op == MASK_FIRST) begin
            exp_scalar = (first_el == VLEN) ? '1 : XLEN'(first_el);
            check({tag, "_first"}, scalar_res, exp_scalar);
        end
        check({tag, "_accepts"}, acc_cnt, nch);
        check({tag, "_nout"}, outq.size(), (op == MASK_POPC || op == MASK_FIRST) ? 0 : nch);
        for (int k = 0; k < outq.size() && k < nch; k++) begin
            logic [CW-1:0] ew, ec, cmp_mask;
            int base = 0;
            for (int b = 0; b < CW; b++) begin
                int  i   = k * CW + b;
                bit  bod = (i < vl);
                bit  act = bod && vm_full[i];
                bit  a   = vs2_full[i];
                bit  c   = ii ? !vs1_full[i] : vs1_full[i];
                case (op)
                    MASK_AND:  begin ew[b] = bod; ec[b] = (a & c) ^ oi; end
                    MASK_OR:   begin ew[b] = bod; ec[b] = (a | c) ^ oi; end
                    MASK_XOR:  begin ew[b] = bod; ec[b] = (a ^ c) ^ oi; end
                    MASK_SBF:  begin ew[b] = act; ec[b] = (i < first_el); end
                    MASK_SIF:  begin ew[b] = act; ec[b] = (i <= first_el); end
                    MASK_SOF:  begin ew[b] = act; ec[b] = (i == first_el); end
                    default:   begin ew[b] = act; ec[b] = a; end
                endcase
            end
            for (int i = 0; i < k * CW; i++) if (i < vl && vm_full[i] && vs2_full[i]) base++;
            cmp_mask = (op == MASK_SBF || op == MASK_SIF || op == MASK_SOF) ? ew : '1;
            check($sformatf("%s_idx%0d", tag, k), outq[k].idx, k);
            check($sformatf("%s_wen%0d", tag, k), outq[k].wen, ew);
            check($sformatf("%s_chunk%0d", tag, k), outq[k].chunk & cmp_mask, ec & cmp_mask);
            if (op == MASK_IOTA) check($sformatf("%s_base%0d", tag, k), outq[k].base, base);
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int guard;
        logic [CW-1:0] x0, x1;
        rst = 1'b1; start = 1'b0; mask_type = MASK_AND; in_inv = 1'b0; out_inv = 1'b0;
        vl_in = '0; in_valid = 1'b0; vs2_chunk = '0; vs1_chunk = '0; vm_chunk = '0;
        out_ready = 1'b1; acc_cnt = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_scalar", scalar_res, 0);
        check("rst_out_chunk", {out_chunk, out_wen, iota_base}, 0);
        rst = 1'b0;

        // POPC over the full register.
        vs2_full = '1; vs1_full = '0; vm_full = '1;
        run_op(MASK_POPC, 128, 0, 0, "popc128");
        check("popc128_const", scalar_res, 128);
        check("popc128_accepts_const", acc_cnt, 4);

        // FIRST with a single set bit, then with that bit masked off.
        vs2_full = '0; vs2_full[70] = 1'b1;
        run_op(MASK_FIRST, 100, 0, 0, "first70");
        check("first70_const", scalar_res, 70);
        vm_full[70] = 1'b0;
        run_op(MASK_FIRST, 100, 0, 0, "first_masked");
        check("first_masked_const", scalar_res, 32'hFFFF_FFFF);

        // SIF/SOF/SBF with bit 40 set.
        vm_full = '1; vs2_full = '0; vs2_full[40] = 1'b1;
        run_op(MASK_SIF, 64, 0, 0, "sif");
        check("sif_c0_const", outq[0].chunk, 32'hFFFF_FFFF);
        check("sif_c1_const", outq[1].chunk, 32'h0000_01FF);
        run_op(MASK_SOF, 64, 0, 0, "sof");
        check("sof_c1_const", outq[1].chunk, 32'h0000_0100);
        run_op(MASK_SBF, 64, 0, 0, "sbf");
        check("sbf_c1_const", outq[1].chunk, 32'h0000_00FF);

        // vl == 0: no chunk requested, done the cycle after start.
        @(posedge clk); #1;
        start = 1'b1; mask_type = MASK_POPC; vl_in = 8'd0;
        @(negedge clk);
        check("vl0_idle_ready", in_ready, 0);
        @(negedge clk);
        check("vl0_done", done, 1);
        check("vl0_in_ready", in_ready, 0);
        check("vl0_popc", scalar_res, 0);
        start = 1'b0;
        run_op(MASK_FIRST, 0, 0, 0, "vl0_first");
        check("vl0_first_const", scalar_res, 32'hFFFF_FFFF);

        // XOR with back-pressure: output held, input stalled.
        vs2_full = {$urandom, $urandom, $urandom, $urandom};
        vs1_full = {$urandom, $urandom, $urandom, $urandom};
        x0 = vs2_full[31:0] ^ ~vs1_full[31:0];
        x1 = vs2_full[63:32] ^ ~vs1_full[63:32];
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mask_type = MASK_XOR; vl_in = 8'd40; in_inv = 1'b1; out_inv = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        vs2_chunk = vs2_full[31:0]; vs1_chunk = vs1_full[31:0]; vm_chunk = '1;
        @(negedge clk);
        check("xor_ready0", in_ready, 1);
        @(posedge clk); #1;
        vs2_chunk = vs2_full[63:32]; vs1_chunk = vs1_full[63:32];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("xor_hold_valid%0d", c), out_valid, 1);
            check($sformatf("xor_hold_chunk%0d", c), out_chunk, x0);
            check($sformatf("xor_hold_ready%0d", c), in_ready, 0);
        end
        check("xor_wen0", out_wen, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        #1;
        check("xor_ready1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("xor_c1_valid", out_valid, 1);
        check("xor_c1_chunk", out_chunk, x1);
        check("xor_c1_wen", out_wen, 32'h0000_00FF);
        check("xor_c1_idx", out_idx, 1);
        guard = 0;
        while (!done && guard < 20) begin @(negedge clk); guard++; end
        check("xor_done", done, 1);
        in_inv = 1'b0;

        // Randomized ops with random back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 24; t++) begin
            int sel = $urandom_range(0, 5);
            int vl  = (sel == 0) ? 0 : (sel == 1) ? 128 : (sel == 2) ? 32 * $urandom_range(1, 4) : $urandom_range(1, 128);
            mask_op_t op = mask_op_t'($urandom_range(0, 8));
            for (int k = 0; k < 4; k++) begin
                vs2_full[k*CW +: CW] = ($urandom_range(0, 1) != 0) ? ($urandom & $urandom & $urandom) : $urandom;
                if (t < 6) vs2_full[k*CW +: CW] = '0;
                vs1_full[k*CW +: CW] = $urandom;
                vm_full[k*CW +: CW]  = ($urandom_range(0, 1) != 0) ? '1 : $urandom;
            end
            if (t == 3) vs2_full[$urandom_range(0, 127)] = 1'b1;
            run_op(op, vl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset in the middle of a run aborts it; the next op starts from zero.
        vs2_full = '1; vm_full = '1;
        @(posedge clk); #1;
        start = 1'b1; mask_type = MASK_POPC; vl_in = 8'd128;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; vs2_chunk = '1; vm_chunk = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(MASK_POPC, 128, 0, 0, "after_rst");
        check("after_rst_const", scalar_res, 128);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
